// File: rtl/running_mean_spike_mc_if.sv
// -----------------------------------------------------------------------------
// running_mean_spike_mc_if
// Purpose : AXI-Stream-style channel bundle (data, channel tag, valid/ready)
//           used for both the sample input and the result output of
//           running_mean_spike_mc.
// Signals : tdata  - payload (sample or {spike, mean})
//           tuser  - channel ID
//           tvalid - producer has a beat
//           tready - consumer takes the beat
// Modports: master drives tdata/tuser/tvalid, slave drives tready.
// -----------------------------------------------------------------------------
interface running_mean_spike_mc_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 2
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/running_mean_spike_mc.sv
// -----------------------------------------------------------------------------
// running_mean_spike_mc
// Purpose : Multi-channel running-mean spike detector. Each channel keeps a
//           mean and a saturating sample count. A sample whose distance from
//           its channel mean exceeds THRESHOLD is flagged as a spike and left
//           out of the mean. Two-stage pipeline: S1 registers the sample,
//           stage 2 reads/updates channel state and loads the output register.
// Ports   : clk         - clock, rising edge
//           rst         - asynchronous active-high reset
//           clr         - synchronous clear of all state, pipeline, counters
//           s_axis      - sample input (tdata = signed X, tuser = channel)
//           m_axis      - result output (tdata = {spike, mean[DATA_W-2:0]},
//                         tuser = channel), full valid/ready backpressure
//           spike_count - saturating count of spike results emitted
//           bad_ch      - sticky: a sample carried an out-of-range channel ID
// -----------------------------------------------------------------------------
module running_mean_spike_mc #(
  parameter int DATA_W    = 32,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int THRESHOLD = 100,
  parameter int MODE      = 0,
  parameter int EMA_SHIFT = 4,
  parameter int N_MAX     = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  running_mean_spike_mc_if.slave  s_axis,
  running_mean_spike_mc_if.master m_axis,
  output logic [15:0]             spike_count,
  output logic                    bad_ch
);

  localparam logic [CH_W:0]   CH_LIM = (CH_W+1)'(CHANNELS);
  localparam logic [DATA_W:0] THR_V  = (DATA_W+1)'(THRESHOLD);
  localparam logic [15:0]     N_SAT  = 16'(N_MAX);

  // Per-channel state
  logic signed [DATA_W-1:0] mean_reg [CHANNELS];
  logic [15:0]              cnt_reg  [CHANNELS];

  // Stage 1
  logic                     s1_valid_reg;
  logic signed [DATA_W-1:0] s1_data_reg;
  logic [CH_W-1:0]          s1_ch_reg;

  // Output register
  logic                     out_valid_reg;
  logic [DATA_W-1:0]        out_data_reg;
  logic [CH_W-1:0]          out_user_reg;

  logic [15:0]              spike_count_reg;
  logic                     bad_ch_reg;

  // Stage-2 datapath
  logic                     en;
  logic                     ch_ok;
  logic signed [DATA_W-1:0] mean_cur;
  logic [15:0]              cnt_cur;
  logic signed [DATA_W:0]   delta;
  logic [DATA_W:0]          abs_delta;
  logic                     first;
  logic                     spike;
  logic [15:0]              cnt_inc;
  logic signed [DATA_W:0]   step;
  logic signed [DATA_W:0]   mean_upd;
  logic signed [DATA_W-1:0] mean_next;
  logic [15:0]              cnt_next;
  logic                     wr;
  logic                     unused_bits;

  // Whole pipeline advances together; a pending unaccepted result freezes it.
  assign en             = !out_valid_reg || m_axis.tready;
  assign s_axis.tready  = en && !clr && !rst;

  // Channel-state read as a mux so an out-of-range ID never indexes past the
  // array; such samples are dropped below anyway.
  always_comb begin
    mean_cur = '0;
    cnt_cur  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s1_ch_reg == CH_W'(i)) begin
        mean_cur = mean_reg[i];
        cnt_cur  = cnt_reg[i];
      end
    end
  end

  assign ch_ok     = {1'b0, s1_ch_reg} < CH_LIM;
  // One extra bit so X - M never wraps.
  assign delta     = {s1_data_reg[DATA_W-1], s1_data_reg} - {mean_cur[DATA_W-1], mean_cur};
  assign abs_delta = delta[DATA_W] ? -delta : delta;
  assign first     = (cnt_cur == 16'd0);
  assign spike     = !first && (abs_delta > THR_V);
  assign cnt_inc   = (cnt_cur >= N_SAT) ? N_SAT : cnt_cur + 16'd1;

  generate
    if (MODE == 0) begin : g_cumulative
      // Signed division truncates toward zero; the divisor is the new count.
      logic [DATA_W:0] div_u;
      assign div_u = (DATA_W+1)'(cnt_inc);
      assign step  = delta / $signed(div_u);
    end else begin : g_ema
      // Arithmetic shift rounds toward minus infinity.
      assign step = delta >>> EMA_SHIFT;
    end
  endgenerate

  // M' lies between M and X, so the low DATA_W bits of the sum are exact.
  assign mean_upd    = {mean_cur[DATA_W-1], mean_cur} + step;
  assign unused_bits = mean_upd[DATA_W];

  always_comb begin
    mean_next = mean_cur;
    cnt_next  = cnt_cur;
    if (first) begin
      mean_next = s1_data_reg;
      cnt_next  = 16'd1;
    end else if (!spike) begin
      mean_next = mean_upd[DATA_W-1:0];
      cnt_next  = cnt_inc;
    end
  end

  assign wr = en && s1_valid_reg && ch_ok;

  // Channel state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mean_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mean_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
    end else if (wr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (s1_ch_reg == CH_W'(i)) begin
          mean_reg[i] <= mean_next;
          cnt_reg[i]  <= cnt_next;
        end
      end
    end
  end

  // Stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_ch_reg    <= '0;
    end else if (clr) begin
      s1_valid_reg <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        s1_data_reg <= s_axis.tdata;
        s1_ch_reg   <= s_axis.tuser;
      end
    end
  end

  // Output register, spike counter and bad-channel flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_user_reg    <= '0;
      spike_count_reg <= '0;
      bad_ch_reg      <= 1'b0;
    end else if (clr) begin
      out_valid_reg   <= 1'b0;
      spike_count_reg <= '0;
      bad_ch_reg      <= 1'b0;
    end else if (en) begin
      out_valid_reg <= wr;
      if (wr) begin
        out_data_reg <= {spike, mean_next[DATA_W-2:0]};
        out_user_reg <= s1_ch_reg;
        if (spike && spike_count_reg != 16'hFFFF) begin
          spike_count_reg <= spike_count_reg + 16'd1;
        end
      end
      if (s1_valid_reg && !ch_ok) begin
        bad_ch_reg <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
  assign m_axis.tuser  = out_user_reg;
  assign spike_count   = spike_count_reg;
  assign bad_ch        = bad_ch_reg;

endmodule

// File: tb/tb_running_mean_spike_mc.sv
// -----------------------------------------------------------------------------
// tb_running_mean_spike_mc
// Two instances share one stimulus port: dut0 is cumulative mode with three
// channels (so ID 3 is out of range), dut1 is EMA mode with EMA_SHIFT 2.
// Expected results are queued when a sample is accepted and popped when the
// matching DUT presents a result that the sink takes.
// -----------------------------------------------------------------------------
module tb_running_mean_spike_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] drv_data = '0;
  logic [1:0]  drv_user = '0;
  logic        drv_valid = 1'b0;
  logic        m_ready = 1'b1;

  logic [15:0] sc0, sc1;
  logic        bad0, bad1;

  running_mean_spike_mc_if #(.DATA_W(32), .USER_W(2)) s0 ();
  running_mean_spike_mc_if #(.DATA_W(32), .USER_W(2)) m0 ();
  running_mean_spike_mc_if #(.DATA_W(32), .USER_W(2)) s1 ();
  running_mean_spike_mc_if #(.DATA_W(32), .USER_W(2)) m1 ();

  assign s0.tdata  = drv_data;
  assign s0.tuser  = drv_user;
  assign s0.tvalid = drv_valid && !sel;
  assign s1.tdata  = drv_data;
  assign s1.tuser  = drv_user;
  assign s1.tvalid = drv_valid && sel;
  assign m0.tready = m_ready;
  assign m1.tready = m_ready;

  running_mean_spike_mc #(
    .DATA_W(32), .CHANNELS(3), .THRESHOLD(100), .MODE(0), .EMA_SHIFT(4), .N_MAX(65535)
  ) dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis(s0.slave), .m_axis(m0.master),
    .spike_count(sc0), .bad_ch(bad0)
  );

  running_mean_spike_mc #(
    .DATA_W(32), .CHANNELS(4), .THRESHOLD(100), .MODE(1), .EMA_SHIFT(2), .N_MAX(65535)
  ) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis(s1.slave), .m_axis(m1.master),
    .spike_count(sc1), .bad_ch(bad1)
  );

  typedef struct {
    bit          dut;
    logic [31:0] x;
    logic [1:0]  ch;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  user;
    int          exp_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bit          st0_prev = 1'b0;
  logic [31:0] st0_data;
  logic [1:0]  st0_user;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Offer one sample; queue its expected result once it is seen to be taken.
  task automatic send(input bit dut, input logic [31:0] x, input logic [1:0] ch,
                      input bit exp_out, input logic [31:0] exp_data);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    sel       = dut;
    drv_data  = x;
    drv_user  = ch;
    drv_valid = 1'b1;
    #1;
    while (!(dut ? s1.tready : s0.tready) && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("accept_within_bound", guard < 50, 1);
    if (exp_out) begin
      e.data    = exp_data;
      e.user    = ch;
      e.exp_cyc = cyc + 2;
      e.chk_lat = m_ready;
      if (dut) q1.push_back(e);
      else     q0.push_back(e);
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic mon();
    exp_t e;
    if (m0.tvalid && m0.tready) begin
      chk("dut0_result_expected", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        $display("dut0 ch%0d tdata 0x%08h (want 0x%08h) cyc %0d", m0.tuser, m0.tdata, e.data, cyc);
        chk("dut0_tdata", m0.tdata, e.data);
        chk("dut0_tuser", m0.tuser, e.user);
        if (e.chk_lat) chk("dut0_latency", cyc, e.exp_cyc);
      end
    end
    if (m0.tvalid && !m0.tready) begin
      if (st0_prev) begin
        chk("dut0_stall_tdata_stable", m0.tdata, st0_data);
        chk("dut0_stall_tuser_stable", m0.tuser, st0_user);
      end
      st0_prev = 1'b1;
      st0_data = m0.tdata;
      st0_user = m0.tuser;
    end else begin
      st0_prev = 1'b0;
    end
    if (m1.tvalid && m1.tready) begin
      chk("dut1_result_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        $display("dut1 ch%0d tdata 0x%08h (want 0x%08h) cyc %0d", m1.tuser, m1.tdata, e.data, cyc);
        chk("dut1_tdata", m1.tdata, e.data);
        chk("dut1_tuser", m1.tuser, e.user);
        if (e.chk_lat) chk("dut1_latency", cyc, e.exp_cyc);
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("all_results_delivered", q0.size() + q1.size(), 0);
  endtask

  initial begin
    vec_t vecs [17];
    int   g;

    // dut0: cumulative mean, threshold 100
    vecs[0]  = '{1'b0, 32'd10,        2'd0, 32'd10};
    vecs[1]  = '{1'b0, 32'd20,        2'd0, 32'd15};
    vecs[2]  = '{1'b0, 32'd30,        2'd0, 32'd20};
    vecs[3]  = '{1'b0, 32'd500,       2'd0, 32'h80000014};
    vecs[4]  = '{1'b0, 32'd24,        2'd0, 32'd21};
    vecs[5]  = '{1'b0, 32'hFFFFFFCE,  2'd1, 32'h7FFFFFCE};
    vecs[6]  = '{1'b0, 32'd7,         2'd2, 32'd7};
    vecs[7]  = '{1'b0, 32'd40,        2'd0, 32'd24};
    vecs[8]  = '{1'b0, 32'd107,       2'd2, 32'd57};
    vecs[9]  = '{1'b0, 32'hFFFFFFD4,  2'd2, 32'h80000039};
    vecs[10] = '{1'b0, 32'hFFFFFFCB,  2'd1, 32'h7FFFFFCD};
    // dut1: EMA, shift 2
    vecs[11] = '{1'b1, 32'd100,       2'd0, 32'd100};
    vecs[12] = '{1'b1, 32'd200,       2'd0, 32'd125};
    vecs[13] = '{1'b1, 32'd180,       2'd0, 32'd138};
    vecs[14] = '{1'b1, 32'd0,         2'd0, 32'h8000008A};
    vecs[15] = '{1'b1, 32'd10,        2'd1, 32'd10};
    vecs[16] = '{1'b1, 32'd3,         2'd1, 32'd8};

    fork
      forever begin
        @(negedge clk);
        #2;
        mon();
      end
      begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_tvalid", m0.tvalid, 0);
    chk("rst_m_tdata", m0.tdata, 0);
    chk("rst_m_tuser", m0.tuser, 0);
    chk("rst_spike_count", sc0, 0);
    chk("rst_bad_ch", bad0, 0);
    chk("rst_s_tready_low", s0.tready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s_tready_after_rst", s0.tready, 1);

    // Table of back-to-back transactions
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].dut, vecs[i].x, vecs[i].ch, 1'b1, vecs[i].exp_data);
    end
    drain();
    chk("dut0_spike_count", sc0, 2);
    chk("dut1_spike_count", sc1, 1);
    chk("dut1_bad_ch_clear", bad1, 0);

    // Out-of-range channel on dut0: consumed, no result, sticky flag
    send(1'b0, 32'd123, 2'd3, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("bad_ch_set", bad0, 1);
    chk("bad_ch_no_output", m0.tvalid, 0);

    // Backpressure: sink stalls for 5 cycles while 3 samples are offered
    @(negedge clk);
    m_ready = 1'b0;
    fork
      begin
        send(1'b0, 32'd36, 2'd0, 1'b1, 32'd26);
        send(1'b0, 32'd40, 2'd0, 1'b1, 32'd28);
        send(1'b0, 32'd44, 2'd0, 1'b1, 32'd30);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("bp_s_tready_low", s0.tready, 0);
        chk("bp_m_tvalid_held", m0.tvalid, 1);
        @(negedge clk);
        m_ready = 1'b1;
      end
    join
    drain();

    // CLR with a sample sitting in S1
    @(negedge clk);
    sel       = 1'b0;
    drv_data  = 32'd99;
    drv_user  = 2'd0;
    drv_valid = 1'b1;
    #1;
    chk("clr_pre_accept", s0.tready, 1);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_s_tready_low", s0.tready, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_m_tvalid", m0.tvalid, 0);
    chk("clr_spike_count", sc0, 0);
    chk("clr_bad_ch", bad0, 0);
    repeat (2) @(negedge clk);
    send(1'b0, 32'd7, 2'd0, 1'b1, 32'd7);
    drain();

    // Asynchronous reset pulse between edges while a result is pending
    @(negedge clk);
    m_ready = 1'b0;
    send(1'b0, 32'd500, 2'd0, 1'b1, 32'h80000007);
    g = 0;
    while (!m0.tvalid && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("pre_rst_m_tvalid", m0.tvalid, 1);
    chk("pre_rst_tdata", m0.tdata, 32'h80000007);
    chk("pre_rst_spike_count", sc0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_m_tvalid", m0.tvalid, 0);
    chk("async_rst_m_tdata", m0.tdata, 0);
    chk("async_rst_spike_count", sc0, 0);
    chk("async_rst_s_tready", s0.tready, 0);
    #1 rst = 1'b0;
    q0.delete();
    m_ready = 1'b1;

    // State was cleared by reset: first-sample rule again
    send(1'b0, 32'd9, 2'd0, 1'b1, 32'd9);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
